// File: rtl/camera_dvp_pkg.sv
// Shared types and constants for the DVP camera transmitter: FSM state
// encoding, RGB565 colour-bar palette and the minimum pclk divider.
package camera_dvp_pkg;

    localparam int DVP_MIN_PCLK_DIV = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ACT_HI = 3'd1,
        ACT_LO = 3'd2,
        HBLANK = 3'd3,
        VBLANK = 3'd4
    } tx_state_t;

    localparam logic [15:0] RGB565_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB565_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB565_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB565_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB565_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB565_RED     = 16'hF800;
    localparam logic [15:0] RGB565_BLUE    = 16'h001F;
    localparam logic [15:0] RGB565_BLACK   = 16'h0000;

    // Colour of bar number idx, left to right across the line.
    function automatic logic [15:0] colour_bar(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = RGB565_WHITE;
            3'd1:    c = RGB565_YELLOW;
            3'd2:    c = RGB565_CYAN;
            3'd3:    c = RGB565_GREEN;
            3'd4:    c = RGB565_MAGENTA;
            3'd5:    c = RGB565_RED;
            3'd6:    c = RGB565_BLUE;
            default: c = RGB565_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/camera_dvp_pclk_gen.sv
// Free-running pixel-clock generator. pclk toggles every PCLK_DIV system
// clocks. pre_fall_out marks the system-clock cycle whose closing edge
// lowers pclk; fall_out is high in the cycle right after that edge.
module camera_dvp_pclk_gen
    import camera_dvp_pkg::*;
#(
    parameter int PCLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic pclk_out,
    output logic pre_fall_out,
    output logic fall_out
);
    localparam int CNT_W = $clog2(PCLK_DIV) + 1;

    if (PCLK_DIV < DVP_MIN_PCLK_DIV) begin : g_div_check
        $error("camera_dvp_pclk_gen: PCLK_DIV below minimum");
    end

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pclk_q, pclk_d;
    logic             fall_q, fall_d;
    logic             wrap_w;

    // Phase counter wraps at PCLK_DIV-1 and flips pclk on the wrap.
    always_comb begin
        wrap_w = (cnt_q == CNT_W'(PCLK_DIV - 1));
        cnt_d  = wrap_w ? '0 : cnt_q + CNT_W'(1);
        pclk_d = wrap_w ? ~pclk_q : pclk_q;
        fall_d = wrap_w & pclk_q;
    end

    // Counter, pclk and fall strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pclk_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pclk_q <= pclk_d;
            fall_q <= fall_d;
        end
    end

    assign pclk_out     = pclk_q;
    assign pre_fall_out = wrap_w & pclk_q;
    assign fall_out     = fall_q;

endmodule

// File: rtl/camera_dvp_tx.sv
// DVP camera transmitter / emulator. Splits 16-bit pixels into two bytes
// (high first) with generated pclk, hs (line valid) and vs (frame valid).
// All line outputs change only on the system edge that lowers pclk, so a
// receiver sampling on pclk rise always sees settled data.
// Build option: define CAMERA_DVP_TX_PATTERN_EN to replace the external
// pull handshake with an internal 8-bar colour generator.
module camera_dvp_tx
    import camera_dvp_pkg::*;
#(
    parameter int          PCLK_DIV        = 2,
    parameter int          H_ACTIVE        = 320,
    parameter int          H_BLANK         = 64,
    parameter int          V_ACTIVE        = 240,
    parameter int          V_BLANK         = 8,
    parameter logic [15:0] UNDERFLOW_PIXEL = 16'hF81F
) (
    input  logic        clk_pixel_in,
    input  logic        rst_n_in,
    input  logic        enable_in,
    input  logic [15:0] pixel_data_in,
    input  logic        pixel_valid_in,
    output logic        pixel_ready_out,
    output logic        pclk_cam_out,
    output logic        hs_cam_out,
    output logic        vs_cam_out,
    output logic [7:0]  data_cam_out,
    output logic        frame_start_out,
    output logic        busy_out,
    output logic        underflow_out
);
    localparam int V_TOTAL = V_ACTIVE + V_BLANK;
    localparam int PIX_W   = $clog2(H_ACTIVE) + 1;
    localparam int LINE_W  = $clog2(V_TOTAL) + 1;
    localparam int BLK_MAX = (H_BLANK > 2 * H_ACTIVE) ? H_BLANK : 2 * H_ACTIVE;
    localparam int BLK_W   = $clog2(BLK_MAX) + 1;

    logic        pclk_w, pre_fall_w, fall_w;
    logic [15:0] src_pixel_w;
    logic        src_valid_w;

    tx_state_t         state_q, state_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [LINE_W-1:0] line_inc_w;
    logic [PIX_W-1:0]  pix_q, pix_d;
    logic [BLK_W-1:0]  blk_q, blk_d;
    logic [7:0]        lo_q, lo_d;
    logic [7:0]        data_q, data_d;
    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic              busy_q, busy_d;
    logic              uf_q, uf_d;
    logic              fs_q, fs_d;

    camera_dvp_pclk_gen #(
        .PCLK_DIV(PCLK_DIV)
    ) u_pclk_gen (
        .clk          (clk_pixel_in),
        .rst_n        (rst_n_in),
        .pclk_out     (pclk_w),
        .pre_fall_out (pre_fall_w),
        .fall_out     (fall_w)
    );

`ifdef CAMERA_DVP_TX_PATTERN_EN
    localparam int BAR_W = (H_ACTIVE / 8 > 0) ? H_ACTIVE / 8 : 1;
    logic [PIX_W-1:0] bar_idx_w;

    assign bar_idx_w       = pix_q / PIX_W'(BAR_W);
    assign src_pixel_w     = colour_bar(bar_idx_w[2:0]);
    assign src_valid_w     = 1'b1;
    assign pixel_ready_out = 1'b0;
`else
    // The pixel is taken in the pre-fall cycle ahead of each high-byte edge.
    assign src_pixel_w     = pixel_valid_in ? pixel_data_in : UNDERFLOW_PIXEL;
    assign src_valid_w     = pixel_valid_in;
    assign pixel_ready_out = pre_fall_w && (state_q == ACT_HI);
`endif

    assign line_inc_w = line_q + LINE_W'(1);

    // Next-state and output decode; everything advances only on pclk fall.
    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        pix_d   = pix_q;
        blk_d   = blk_q;
        lo_d    = lo_q;
        data_d  = data_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        busy_d  = busy_q;
        uf_d    = uf_q;
        // frame_start is raised on the fall edge and dropped in the cycle
        // the fall strobe reports that edge, giving one system-clock pulse.
        fs_d    = fs_q & ~fall_w;

        if (pre_fall_w) begin
            case (state_q)
                IDLE: begin
                    hs_d   = 1'b0;
                    vs_d   = 1'b0;
                    data_d = '0;
                    if (enable_in) begin
                        state_d = ACT_HI;
                        line_d  = '0;
                        pix_d   = '0;
                        busy_d  = 1'b1;
                        fs_d    = 1'b1;
                    end
                end
                ACT_HI: begin
                    hs_d    = 1'b1;
                    vs_d    = 1'b1;
                    data_d  = src_pixel_w[15:8];
                    lo_d    = src_pixel_w[7:0];
                    uf_d    = uf_q | ~src_valid_w;
                    state_d = ACT_LO;
                end
                ACT_LO: begin
                    data_d = lo_q;
                    if (pix_q == PIX_W'(H_ACTIVE - 1)) begin
                        pix_d   = '0;
                        blk_d   = '0;
                        state_d = HBLANK;
                    end else begin
                        pix_d   = pix_q + PIX_W'(1);
                        state_d = ACT_HI;
                    end
                end
                HBLANK: begin
                    hs_d   = 1'b0;
                    vs_d   = (line_q < LINE_W'(V_ACTIVE));
                    data_d = '0;
                    if (blk_q == BLK_W'(H_BLANK - 1)) begin
                        blk_d  = '0;
                        line_d = line_inc_w;
                        if (line_inc_w < LINE_W'(V_ACTIVE)) begin
                            state_d = ACT_HI;
                        end else if (line_inc_w < LINE_W'(V_TOTAL)) begin
                            state_d = VBLANK;
                        end else begin
                            line_d = '0;
                            if (enable_in) begin
                                state_d = ACT_HI;
                                fs_d    = 1'b1;
                            end else begin
                                state_d = IDLE;
                                busy_d  = 1'b0;
                            end
                        end
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
                VBLANK: begin
                    hs_d   = 1'b0;
                    vs_d   = 1'b0;
                    data_d = '0;
                    if (blk_q == BLK_W'(2 * H_ACTIVE - 1)) begin
                        blk_d   = '0;
                        state_d = HBLANK;
                    end else begin
                        blk_d = blk_q + BLK_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State, counters, byte lane and status flags.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            line_q  <= '0;
            pix_q   <= '0;
            blk_q   <= '0;
            lo_q    <= '0;
            data_q  <= '0;
            hs_q    <= 1'b0;
            vs_q    <= 1'b0;
            busy_q  <= 1'b0;
            uf_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            line_q  <= line_d;
            pix_q   <= pix_d;
            blk_q   <= blk_d;
            lo_q    <= lo_d;
            data_q  <= data_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            busy_q  <= busy_d;
            uf_q    <= uf_d;
            fs_q    <= fs_d;
        end
    end

    assign pclk_cam_out    = pclk_w;
    assign hs_cam_out      = hs_q;
    assign vs_cam_out      = vs_q;
    assign data_cam_out    = data_q;
    assign frame_start_out = fs_q;
    assign busy_out        = busy_q;
    assign underflow_out   = uf_q;

endmodule
